// File: rtl/fetch_ibuf_stage.sv
// In-order instruction fetch queue between the PC generator / AR issue logic and decode.
// Tracks outstanding AXI reads by ID and hands instructions to decode in program order.
module fetch_ibuf_stage #(
    parameter int DEPTH    = 4,
    parameter int ID_W     = 4,
    parameter int FETCH_ID = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    output logic            issue_allowin,
    input  logic            issue_fire,
    input  logic [31:0]     issue_pc,
    input  logic            issue_adel,
    input  logic            issue_dsi,
    input  logic            fetch_axi_rvalid,
    input  logic [31:0]     fetch_axi_rdata,
    input  logic [ID_W-1:0] fetch_axi_rid,
    output logic            fetch_axi_rready,
    input  logic            decode_allowin,
    output logic            fe_to_de_valid,
    output logic [31:0]     PC_IF_ID,
    output logic [31:0]     PC_add_4_IF_ID,
    output logic [31:0]     IR_IF_ID,
    output logic            PC_AdEL_IF_ID,
    output logic            DSI_IF_ID
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]      pc_q [DEPTH];
    logic [31:0]      ir_q [DEPTH];
    logic [DEPTH-1:0] adel_q, dsi_q, filled_q;
    logic [AW-1:0]    alloc_ptr_q, fill_ptr_q, head_ptr_q;
    logic [CW-1:0]    occ_q, pend_q, drop_q;
    logic [CW-1:0]    occ_d, pend_d, drop_d;

    logic alloc, alloc_bus, beat_acc, fill, deq;

    assign issue_allowin    = occ_q < CW'(DEPTH);
    assign fetch_axi_rready = (pend_q != '0) || (drop_q != '0);
    assign beat_acc         = fetch_axi_rvalid && fetch_axi_rready &&
                              (fetch_axi_rid == ID_W'(FETCH_ID));
    assign fill             = beat_acc && (drop_q == '0);
    assign alloc            = issue_fire && issue_allowin;
    assign alloc_bus        = alloc && !issue_adel;
    assign fe_to_de_valid   = filled_q[head_ptr_q] && (occ_q != '0) && !flush;
    assign deq              = fe_to_de_valid && decode_allowin;

    assign PC_IF_ID       = pc_q[head_ptr_q];
    assign PC_add_4_IF_ID = pc_q[head_ptr_q] + 32'd4;
    assign IR_IF_ID       = ir_q[head_ptr_q];
    assign PC_AdEL_IF_ID  = adel_q[head_ptr_q];
    assign DSI_IF_ID      = dsi_q[head_ptr_q];

    always_comb begin
        occ_d  = occ_q + CW'(alloc) - CW'(deq);
        pend_d = pend_q + CW'(alloc_bus) - CW'(fill);
        drop_d = drop_q - CW'(beat_acc && (drop_q != '0));
        if (flush) begin
            occ_d  = '0;
            pend_d = '0;
            // every request still owed by the bus must be absorbed later
            drop_d = drop_q + pend_q + CW'(alloc_bus) - CW'(beat_acc);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i] <= '0;
                ir_q[i] <= '0;
            end
            adel_q      <= '0;
            dsi_q       <= '0;
            filled_q    <= '0;
            alloc_ptr_q <= '0;
            fill_ptr_q  <= '0;
            head_ptr_q  <= '0;
            occ_q       <= '0;
            pend_q      <= '0;
            drop_q      <= '0;
        end else begin
            occ_q  <= occ_d;
            pend_q <= pend_d;
            drop_q <= drop_d;
            if (flush) begin
                filled_q    <= '0;
                alloc_ptr_q <= '0;
                fill_ptr_q  <= '0;
                head_ptr_q  <= '0;
            end else begin
                if (alloc) begin
                    pc_q[alloc_ptr_q]     <= issue_pc;
                    ir_q[alloc_ptr_q]     <= '0;
                    adel_q[alloc_ptr_q]   <= issue_adel;
                    dsi_q[alloc_ptr_q]    <= issue_dsi;
                    filled_q[alloc_ptr_q] <= issue_adel;
                    alloc_ptr_q           <= alloc_ptr_q + 1'b1;
                end
                if (fill) begin
                    ir_q[fill_ptr_q]     <= fetch_axi_rdata;
                    filled_q[fill_ptr_q] <= 1'b1;
                end
                // ADEL issues only happen with nothing pending, so fill_ptr sits on that slot
                if (fill || (alloc && issue_adel)) begin
                    fill_ptr_q <= fill_ptr_q + 1'b1;
                end
                if (deq) begin
                    filled_q[head_ptr_q] <= 1'b0;
                    head_ptr_q           <= head_ptr_q + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_fetch_ibuf_stage.sv
// Scoreboard bench for fetch_ibuf_stage: expected decode hand-offs are queued at issue time
// and compared by a monitor whenever decode accepts an entry.
module tb_fetch_ibuf_stage;
    logic        clk, rst, flush;
    logic        issue_allowin, issue_fire, issue_adel, issue_dsi;
    logic [31:0] issue_pc;
    logic        fetch_axi_rvalid, fetch_axi_rready;
    logic [31:0] fetch_axi_rdata;
    logic [3:0]  fetch_axi_rid;
    logic        decode_allowin, fe_to_de_valid;
    logic [31:0] PC_IF_ID, PC_add_4_IF_ID, IR_IF_ID;
    logic        PC_AdEL_IF_ID, DSI_IF_ID;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
        logic        adel;
        logic        dsi;
    } exp_t;
    exp_t exp_q[$];

    fetch_ibuf_stage #(.DEPTH(4), .ID_W(4), .FETCH_ID(0)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .issue_allowin(issue_allowin), .issue_fire(issue_fire), .issue_pc(issue_pc),
        .issue_adel(issue_adel), .issue_dsi(issue_dsi),
        .fetch_axi_rvalid(fetch_axi_rvalid), .fetch_axi_rdata(fetch_axi_rdata),
        .fetch_axi_rid(fetch_axi_rid), .fetch_axi_rready(fetch_axi_rready),
        .decode_allowin(decode_allowin), .fe_to_de_valid(fe_to_de_valid),
        .PC_IF_ID(PC_IF_ID), .PC_add_4_IF_ID(PC_add_4_IF_ID), .IR_IF_ID(IR_IF_ID),
        .PC_AdEL_IF_ID(PC_AdEL_IF_ID), .DSI_IF_ID(DSI_IF_ID)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // decode-side monitor: every accepted hand-off must match the oldest expected entry
    always @(negedge clk) begin
        exp_t e;
        if (!rst && fe_to_de_valid && decode_allowin) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL deq_unexpected: got pc=%h ir=%h, required no dequeue", PC_IF_ID, IR_IF_ID);
            end else begin
                e = exp_q.pop_front();
                if (PC_IF_ID !== e.pc || IR_IF_ID !== e.ir || PC_AdEL_IF_ID !== e.adel ||
                    DSI_IF_ID !== e.dsi || PC_add_4_IF_ID !== e.pc + 32'd4) begin
                    errors++;
                    $display("FAIL deq_entry: got pc=%h pc4=%h ir=%h adel=%b dsi=%b, required pc=%h pc4=%h ir=%h adel=%b dsi=%b",
                             PC_IF_ID, PC_add_4_IF_ID, IR_IF_ID, PC_AdEL_IF_ID, DSI_IF_ID,
                             e.pc, e.pc + 32'd4, e.ir, e.adel, e.dsi);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] ir, input logic adel, input logic dsi);
        exp_t e;
        e.pc = pc; e.ir = ir; e.adel = adel; e.dsi = dsi;
        exp_q.push_back(e);
    endtask

    task automatic do_issue(input logic [31:0] pc, input logic adel, input logic dsi);
        issue_fire = 1'b1; issue_pc = pc; issue_adel = adel; issue_dsi = dsi;
        step();
        issue_fire = 1'b0; issue_adel = 1'b0; issue_dsi = 1'b0;
    endtask

    task automatic do_beat(input logic [31:0] data, input logic [3:0] id);
        fetch_axi_rvalid = 1'b1; fetch_axi_rdata = data; fetch_axi_rid = id;
        step();
        fetch_axi_rvalid = 1'b0; fetch_axi_rid = 4'd0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d entries still expected, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) step();
        checks++;
        if (issue_allowin !== 1'b1 || fetch_axi_rready !== 1'b0 || fe_to_de_valid !== 1'b0 ||
            PC_IF_ID !== 32'd0 || PC_add_4_IF_ID !== 32'd4 || IR_IF_ID !== 32'd0 ||
            PC_AdEL_IF_ID !== 1'b0 || DSI_IF_ID !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got allowin=%b rready=%b valid=%b pc=%h pc4=%h ir=%h adel=%b dsi=%b, required 1 0 0 0 4 0 0 0",
                     issue_allowin, fetch_axi_rready, fe_to_de_valid, PC_IF_ID, PC_add_4_IF_ID,
                     IR_IF_ID, PC_AdEL_IF_ID, DSI_IF_ID);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        decode_allowin = 1'b1;
        push_exp(32'hbfc00000, 32'h24080001, 1'b0, 1'b0);
        do_issue(32'hbfc00000, 1'b0, 1'b0);
        checks++;
        if (fe_to_de_valid !== 1'b0) begin
            errors++; $display("FAIL single_early_valid: got %b, required 0", fe_to_de_valid);
        end
        step();
        checks++;
        if (fetch_axi_rready !== 1'b1) begin
            errors++; $display("FAIL single_rready: got %b, required 1", fetch_axi_rready);
        end
        do_beat(32'h24080001, 4'd0);
        checks++;
        if (fe_to_de_valid !== 1'b1 || IR_IF_ID !== 32'h24080001 || PC_add_4_IF_ID !== 32'hbfc00004) begin
            errors++;
            $display("FAIL single_valid: got valid=%b ir=%h pc4=%h, required 1 24080001 bfc00004",
                     fe_to_de_valid, IR_IF_ID, PC_add_4_IF_ID);
        end
        step();
        checks++;
        if (fe_to_de_valid !== 1'b0) begin
            errors++; $display("FAIL single_one_cycle: got valid=%b, required 0", fe_to_de_valid);
        end
        wait_drain("single");
    endtask

    task automatic test_fill_depth();
        decode_allowin = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (issue_allowin !== 1'b1) begin
                errors++; $display("FAIL depth_allowin_%0d: got %b, required 1", k, issue_allowin);
            end
            push_exp(32'h00001000 + 32'(4 * k), 32'ha0000000 + 32'(k), 1'b0, 1'b0);
            do_issue(32'h00001000 + 32'(4 * k), 1'b0, 1'b0);
        end
        checks++;
        if (issue_allowin !== 1'b0) begin
            errors++; $display("FAIL depth_full: got allowin=%b, required 0", issue_allowin);
        end
        do_issue(32'hdeadbee0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) do_beat(32'ha0000000 + 32'(k), 4'd0);
        checks++;
        if (issue_allowin !== 1'b0 || fetch_axi_rready !== 1'b0) begin
            errors++;
            $display("FAIL depth_still_full: got allowin=%b rready=%b, required 0 0", issue_allowin, fetch_axi_rready);
        end
        decode_allowin = 1'b1;
        step();
        checks++;
        if (issue_allowin !== 1'b1) begin
            errors++; $display("FAIL depth_reopen: got allowin=%b, required 1", issue_allowin);
        end
        wait_drain("depth");
    endtask

    task automatic test_interleaved();
        decode_allowin = 1'b1;
        push_exp(32'hfffffffc, 32'h11111111, 1'b0, 1'b1);
        do_issue(32'hfffffffc, 1'b0, 1'b1);
        push_exp(32'h00000000, 32'h22222222, 1'b0, 1'b0);
        do_issue(32'h00000000, 1'b0, 1'b0);
        do_beat(32'hdeadbeef, 4'd1);
        checks++;
        if (fe_to_de_valid !== 1'b0) begin
            errors++; $display("FAIL ileave_foreign_beat: got valid=%b, required 0", fe_to_de_valid);
        end
        do_beat(32'h11111111, 4'd0);
        do_beat(32'h0badf00d, 4'd1);
        do_beat(32'h22222222, 4'd0);
        wait_drain("ileave");
    endtask

    task automatic test_flush();
        decode_allowin = 1'b0;
        for (int k = 0; k < 3; k++) do_issue(32'h00002000 + 32'(4 * k), 1'b0, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if (fe_to_de_valid !== 1'b0 || issue_allowin !== 1'b1 || fetch_axi_rready !== 1'b1) begin
            errors++;
            $display("FAIL flush_after: got valid=%b allowin=%b rready=%b, required 0 1 1",
                     fe_to_de_valid, issue_allowin, fetch_axi_rready);
        end
        decode_allowin = 1'b1;
        push_exp(32'h80000180, 32'h00000044, 1'b0, 1'b0);
        do_issue(32'h80000180, 1'b0, 1'b0);
        do_beat(32'h00000011, 4'd0);
        do_beat(32'h00000022, 4'd0);
        do_beat(32'h00000033, 4'd0);
        checks++;
        if (fe_to_de_valid !== 1'b0) begin
            errors++; $display("FAIL flush_dropped_visible: got valid=%b ir=%h, required 0", fe_to_de_valid, IR_IF_ID);
        end
        do_beat(32'h00000044, 4'd0);
        checks++;
        if (fe_to_de_valid !== 1'b1 || IR_IF_ID !== 32'h00000044 || PC_IF_ID !== 32'h80000180) begin
            errors++;
            $display("FAIL flush_new_fetch: got valid=%b pc=%h ir=%h, required 1 80000180 00000044",
                     fe_to_de_valid, PC_IF_ID, IR_IF_ID);
        end
        wait_drain("flush");
        checks++;
        if (fetch_axi_rready !== 1'b0) begin
            errors++; $display("FAIL flush_rready_idle: got %b, required 0", fetch_axi_rready);
        end
    endtask

    task automatic test_adel();
        decode_allowin = 1'b1;
        push_exp(32'hbfc00001, 32'h0, 1'b1, 1'b0);
        fetch_axi_rvalid = 1'b1; fetch_axi_rdata = 32'h00000099; fetch_axi_rid = 4'd0;
        do_issue(32'hbfc00001, 1'b1, 1'b0);
        checks++;
        if (fe_to_de_valid !== 1'b1 || IR_IF_ID !== 32'h0 || PC_AdEL_IF_ID !== 1'b1 || fetch_axi_rready !== 1'b0) begin
            errors++;
            $display("FAIL adel_entry: got valid=%b ir=%h adel=%b rready=%b, required 1 0 1 0",
                     fe_to_de_valid, IR_IF_ID, PC_AdEL_IF_ID, fetch_axi_rready);
        end
        fetch_axi_rvalid = 1'b0;
        step();
        push_exp(32'h00003000, 32'h00000077, 1'b0, 1'b0);
        do_issue(32'h00003000, 1'b0, 1'b0);
        do_beat(32'h00000077, 4'd0);
        wait_drain("adel");
    endtask

    task automatic test_reset_midop();
        decode_allowin = 1'b0;
        do_issue(32'h00004000, 1'b0, 1'b0);
        do_issue(32'h00004004, 1'b0, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (fetch_axi_rready !== 1'b0 || fe_to_de_valid !== 1'b0 || issue_allowin !== 1'b1) begin
            errors++;
            $display("FAIL rst_midop: got rready=%b valid=%b allowin=%b, required 0 0 1",
                     fetch_axi_rready, fe_to_de_valid, issue_allowin);
        end
        decode_allowin = 1'b1;
        push_exp(32'h00004100, 32'h00000055, 1'b0, 1'b0);
        do_issue(32'h00004100, 1'b0, 1'b0);
        do_beat(32'h00000055, 4'd0);
        wait_drain("rst_midop");
    endtask

    task automatic test_back_to_back();
        int          n_iss = 0;
        int          occ_m = 0;
        logic [31:0] rsp_q[$];
        logic [31:0] pc;
        for (int cyc = 0; cyc < 600 && !(n_iss == 20 && exp_q.size() == 0); cyc++) begin
            decode_allowin = ($urandom_range(0, 3) != 0);
            checks++;
            if (issue_allowin !== (occ_m < 4)) begin
                errors++; $display("FAIL b2b_allowin cyc %0d: got %b, required %b", cyc, issue_allowin, occ_m < 4);
            end
            checks++;
            if (fetch_axi_rready !== (rsp_q.size() != 0)) begin
                errors++; $display("FAIL b2b_rready cyc %0d: got %b, required %b", cyc, fetch_axi_rready, rsp_q.size() != 0);
            end
            fetch_axi_rvalid = 1'b0; fetch_axi_rid = 4'd0;
            if (rsp_q.size() != 0 && $urandom_range(0, 3) != 0) begin
                fetch_axi_rvalid = 1'b1;
                if ($urandom_range(0, 7) == 0) begin
                    fetch_axi_rid = 4'd1; fetch_axi_rdata = 32'hbad0bad0;
                end else begin
                    fetch_axi_rdata = rsp_q.pop_front();
                end
            end
            issue_fire = 1'b0;
            if (n_iss < 20 && issue_allowin && $urandom_range(0, 2) != 0) begin
                pc = 32'h00400000 + 32'(4 * n_iss);
                issue_fire = 1'b1; issue_pc = pc; issue_adel = 1'b0; issue_dsi = pc[2];
                push_exp(pc, pc ^ 32'h3c1d0000, 1'b0, pc[2]);
                rsp_q.push_back(pc ^ 32'h3c1d0000);
                n_iss++;
                occ_m++;
            end
            if (fe_to_de_valid && decode_allowin) occ_m--;
            step();
        end
        issue_fire = 1'b0; fetch_axi_rvalid = 1'b0; issue_dsi = 1'b0;
        checks++;
        if (n_iss != 20 || exp_q.size() != 0) begin
            errors++; $display("FAIL b2b_complete: got %0d issued %0d outstanding, required 20 issued 0 outstanding", n_iss, exp_q.size());
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        issue_fire = 1'b0; issue_pc = '0; issue_adel = 1'b0; issue_dsi = 1'b0;
        fetch_axi_rvalid = 1'b0; fetch_axi_rdata = '0; fetch_axi_rid = '0;
        decode_allowin = 1'b0;
        test_reset();
        test_single();
        test_fill_depth();
        test_interleaved();
        test_flush();
        test_adel();
        test_reset_midop();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_ibuf_stage.md
# fetch_ibuf_stage

Parametrised fetch stage that replaces the single-entry instruction holding register with a DEPTH-entry in-order fetch queue, so the PC generator can keep several instruction reads outstanding on the shared AXI read channel. The stage sits between the PC generator / AR issue logic and the decode stage. It records each issued fetch, matches returning R beats by ID, and presents instructions to decode in program order. A flush (exception, eret, or branch redirect) drops all queued entries and silently discards responses still in flight.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2.
- ID_W, 4: AXI ID width.
- FETCH_ID, 0: AXI ID used for instruction reads.

Ports. Reset is `rst`, synchronous, active-high; the clock is `clk`.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  discard all entries and in-flight fetches
- issue_allowin  out  1  high when the PC generator may issue (occupied < DEPTH)
- issue_fire  in  1  one fetch issued this cycle (AR handshake done, or an ADEL pseudo-fetch)
- issue_pc  in  32  PC of the issued fetch
- issue_adel  in  1  PC address error; no bus request was made
- issue_dsi  in  1  delay-slot tag of the issued fetch
- fetch_axi_rvalid  in  1  R valid
- fetch_axi_rdata  in  32  R data
- fetch_axi_rid  in  ID_W  R ID
- fetch_axi_rready  out  1  ready for R beats carrying FETCH_ID
- decode_allowin  in  1  decode accepts this cycle
- fe_to_de_valid  out  1  head entry valid toward decode
- PC_IF_ID  out  32  head PC
- PC_add_4_IF_ID  out  32  head PC + 4, modulo 2^32
- IR_IF_ID  out  32  head instruction (0 for ADEL entries)
- PC_AdEL_IF_ID  out  1  head ADEL flag
- DSI_IF_ID  out  1  head delay-slot flag

## Operation
- Storage: circular queue of DEPTH entries. Each entry holds {pc, adel, dsi, ir, filled}.
- Pointers: alloc_ptr, fill_ptr, head_ptr, each log2(DEPTH) bits and wrapping.
- Counters: occ (allocated entries), pend (bus fetches without data), drop (responses to discard). Each is log2(DEPTH)+1 bits wide.
- Allocate: on issue_fire && issue_allowin, write {pc, adel, dsi} at alloc_ptr and advance alloc_ptr.
  - Non-ADEL issue: filled=0, pend+1.
  - ADEL issue: filled=1, ir=0, pend unchanged. The issuer only makes an ADEL issue when pend==0.
  - issue_fire while issue_allowin=0 is ignored.
- Fill: an R beat is accepted when rvalid && rready && rid==FETCH_ID.
  - drop>0: discard the beat, drop−1.
  - Otherwise write rdata to ir[fill_ptr], set filled, advance fill_ptr, pend−1.
  - Beats with rid≠FETCH_ID are never consumed and leave all state unchanged.
- fetch_axi_rready = (pend>0) || (drop>0). The interconnect qualifies it by ID.
- Dequeue: fe_to_de_valid = filled[head_ptr] && occ>0 && !flush. On fe_to_de_valid && decode_allowin, clear the entry, advance head_ptr, occ−1.
- Head outputs come combinationally from the head entry. PC_add_4_IF_ID = pc+4, with carry dropped.
- issue_allowin = (occ < DEPTH).
- Flush cycle:
  - All filled bits clear and occ, pend go to 0.
  - All three pointers reset to 0.
  - drop becomes drop + pend + (non-ADEL issue_fire this cycle) − (a beat accepted this cycle), so every issued request is eventually absorbed.
  - No dequeue happens.
- Simultaneous allocate, fill and dequeue in one cycle are all legal; occ and pend update by their net change.
- The same-cycle fill of the head entry is not visible until the next cycle; there is no bypass.

## Timing
- Reset: all queue state 0, occ=pend=drop=0.
  - Outputs: issue_allowin=1, fetch_axi_rready=0, fe_to_de_valid=0.
  - PC_IF_ID=IR_IF_ID=0, PC_add_4_IF_ID=4, PC_AdEL_IF_ID=DSI_IF_ID=0.
- Latency: R beat accepted in cycle N gives fe_to_de_valid in N+1 when that entry is at the head. An ADEL issue in cycle N gives valid in N+1.
- Throughput: one issue, one fill and one dequeue per cycle, sustained.
- Full queue (occ==DEPTH): issue_allowin=0 in the same cycle that occ reaches DEPTH. It rises the cycle after a dequeue.
- After a flush, the earliest new issue is in cycle N+1. Its data is accepted only after drop reaches 0, because responses return in order for a single ID.
- rst asserted mid-operation clears drop as well. The system resets the AXI interconnect together with this stage.

## Test plan
- Single fetch: issue PC=0xbfc00000, R beat rdata=0x24080001 two cycles later, decode_allowin=1 → one cycle of fe_to_de_valid with IR_IF_ID=0x24080001, PC_add_4_IF_ID=0xbfc00004.
- Fill to depth: DEPTH=4, issue 4 PCs back-to-back with decode_allowin=0 → issue_allowin=0 after the 4th. Release decode → PCs come out in order, and issue_allowin=1 one cycle after the first dequeue.
- Interleaved IDs: R beat with rid=1 between fetch beats → the rid=1 beat is ignored and the fetch order is intact.
- Flush with 3 pending: flush, then issue PC=0x80000180, then 4 R beats 0x11, 0x22, 0x33, 0x44 → the first three are dropped and decode sees only IR=0x44 at PC 0x80000180.
- ADEL: issue_adel with pc=0xbfc00001 → valid next cycle with IR_IF_ID=0, PC_AdEL_IF_ID=1, and no R beat consumed.
- Wrap and simultaneous events: run 20 fetches with random decode_allowin stalls and issue/fill/dequeue in the same cycle → no loss or duplication, occ never exceeds 4, and pointers wrap correctly.
